// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed display scanner.
// Holds the digit width, the default parameter values, and the helper
// functions used to build the digit-enable bus. The helpers work on the
// widest supported display (8 digits); callers slice the result down to
// their own digit count.
package display_pkg;

  localparam int DIGIT_W        = 4;
  localparam int MAX_DIGITS     = 8;
  localparam int MAX_VAL_W      = DIGIT_W * MAX_DIGITS;
  localparam int DEF_NUM_DIGITS = 4;
  localparam int DEF_PRESCALE   = 1000;

  // One-hot select for digit position idx.
  function automatic logic [MAX_DIGITS-1:0] onehot(input int idx);
    onehot = MAX_DIGITS'(1) << idx;
  endfunction

  // Bit i is set when digit i is a leading zero: nibbles i..num_digits-1
  // are all zero. Digit 0 always stays visible, so bit 0 is never set.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [MAX_VAL_W-1:0] val,
                                                    input int                    num_digits);
    logic all_zero;
    lz_mask  = '0;
    all_zero = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
      if (i < num_digits) begin
        all_zero   = all_zero & (val[i*DIGIT_W +: DIGIT_W] == '0);
        lz_mask[i] = all_zero;
      end
    end
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Digit-rate prescaler for the display scanner.
// The counter runs 0..PRESCALE-1 and wraps. tick is registered, so it is
// high for the one cycle after the counter reaches PRESCALE-1; that lag
// lines the first tick up with the first digit entered after reset so
// every digit, including the very first, is held exactly PRESCALE cycles.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   tick  : one-cycle pulse, once every PRESCALE cycles
module scan_tick_gen
  import display_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CNT_MAX);
      cnt  <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed hex display scanner feeding a 4-bit-to-7-segment decoder.
// A loaded value is parked in a shadow register and only copied to the
// displayed (active) register at a frame wrap, so a frame never shows a mix
// of old and new digits. A load landing exactly on the wrap edge goes
// straight to the active register.
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   load        : one-cycle strobe, capture value
//   value       : hex value, nibble 0 is the least significant digit
//   blank_lz    : 1 = suppress leading zeros
//   nibble      : digit code for the segment decoder
//   digit_en    : one-hot, active-high enable of the digit being shown
//   digit_idx   : index of the digit being shown
//   frame_start : one-cycle pulse when digit 0 starts a frame
module display_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int PRESCALE   = DEF_PRESCALE
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0]   value,
  input  logic                            blank_lz,
  output logic [DIGIT_W-1:0]              nibble,
  output logic [NUM_DIGITS-1:0]           digit_en,
  output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
  output logic                            frame_start
);

  localparam int VAL_W = DIGIT_W * NUM_DIGITS;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic             tick;
  logic             started;   // low until the first edge after reset
  logic [VAL_W-1:0] active, active_n;
  logic [VAL_W-1:0] shadow, shadow_n;
  logic             pending, pending_n;

  logic                  enter, wrap;
  logic [IDX_W-1:0]      idx_n;
  logic [DIGIT_W-1:0]    nibble_n;
  logic [NUM_DIGITS-1:0] en_n;
  logic                  fs_n;
  logic [MAX_DIGITS-1:0] oh_full, lz_full;

  scan_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    active_n  = active;
    shadow_n  = shadow;
    pending_n = pending;
    idx_n     = digit_idx;
    nibble_n  = nibble;
    en_n      = digit_en;
    fs_n      = 1'b0;

    // The first edge after reset enters digit 0 just like a frame wrap,
    // but it does not swap buffers.
    enter = !started || tick;
    wrap  = started && tick && (digit_idx == LAST_IDX);

    if (!started || wrap)
      idx_n = '0;
    else if (tick)
      idx_n = digit_idx + 1'b1;

    if (wrap) begin
      pending_n = 1'b0;
      if (load) begin
        // Load on the wrap edge wins outright; any parked shadow is dropped.
        active_n = value;
        shadow_n = value;
      end else if (pending) begin
        active_n = shadow;
      end
    end else if (load) begin
      shadow_n  = value;
      pending_n = 1'b1;
    end

    // Outputs are computed from the post-swap value so the digit 0 entered
    // on a wrap already shows the new value.
    oh_full = onehot(int'(idx_n));
    lz_full = lz_mask(MAX_VAL_W'(active_n), NUM_DIGITS);

    if (enter) begin
      nibble_n = active_n[int'(idx_n)*DIGIT_W +: DIGIT_W];
      en_n     = oh_full[NUM_DIGITS-1:0] & ~(blank_lz ? lz_full[NUM_DIGITS-1:0] : '0);
      fs_n     = (idx_n == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started     <= 1'b0;
      active      <= '0;
      shadow      <= '0;
      pending     <= 1'b0;
      digit_idx   <= '0;
      nibble      <= '0;
      digit_en    <= '0;
      frame_start <= 1'b0;
    end else begin
      started     <= 1'b1;
      active      <= active_n;
      shadow      <= shadow_n;
      pending     <= pending_n;
      digit_idx   <= idx_n;
      nibble      <= nibble_n;
      digit_en    <= en_n;
      frame_start <= fs_n;
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner with NUM_DIGITS=4, PRESCALE=4.
// A scoreboard process predicts every output from the edge count since reset
// release and the load/blank inputs; directed frames add literal checks.
module tb_display_scanner;
  import display_pkg::*;

  localparam int N = 4;
  localparam int P = 4;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        load     = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] value    = '0;
  logic [3:0]  nibble;
  logic [3:0]  digit_en;
  logic [1:0]  digit_idx;
  logic        frame_start;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  display_scanner #(.NUM_DIGITS(N), .PRESCALE(P)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .value       (value),
    .blank_lz    (blank_lz),
    .nibble      (nibble),
    .digit_en    (digit_en),
    .digit_idx   (digit_idx),
    .frame_start (frame_start)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge: load is high across exactly one rising edge
  // and still visible at the following falling edge for the scoreboard.
  task automatic sched_load(input logic [15:0] v);
    fork
      begin
        #1;
        load  = 1'b1;
        value = v;
        @(negedge clk);
        #1;
        load = 1'b0;
      end
    join_none
  endtask

  task automatic set_blank(input logic b);
    fork
      begin
        #1;
        blank_lz = b;
      end
    join_none
  endtask

  // Called at the falling edge where digit 0 of a frame has just been
  // entered; returns at the falling edge where the next frame begins.
  task automatic expect_frame(input string tag, input logic [15:0] nibs, input logic [15:0] ens,
                              input bit l1, input logic [15:0] v1,
                              input bit l2, input logic [15:0] v2,
                              input bit lw, input logic [15:0] vw);
    for (int d = 0; d < N; d++) begin
      check($sformatf("%s.d%0d.fs", tag, d), 32'(frame_start), 32'(d == 0));
      check($sformatf("%s.d%0d.idx", tag, d), 32'(digit_idx), 32'(d));
      check($sformatf("%s.d%0d.nib", tag, d), 32'(nibble), 32'(nibs[4*d +: 4]));
      check($sformatf("%s.d%0d.en", tag, d), 32'(digit_en), 32'(ens[4*d +: 4]));
      if (d == 1 && l1) sched_load(v1);
      if (d == 2 && l2) sched_load(v2);
      if (d == N - 1 && lw) begin
        repeat (P - 1) @(negedge clk);
        sched_load(vw);
        @(negedge clk);
      end else begin
        repeat (P) @(negedge clk);
      end
    end
  endtask

  // Scoreboard: edge e (1-based after release) is inside digit ((e-1)/P)%N;
  // a digit is entered when (e-1)%P==0; every N*P edges after the first is
  // a frame wrap where the buffered value becomes visible.
  initial begin : scoreboard
    int          e;
    int          digit;
    bit          entering, is_wrap, blanked;
    logic [15:0] m_active, m_shadow;
    bit          m_pending;
    int          m_idx;
    logic [3:0]  m_nib, m_en;
    bit          m_fs;
    e = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        e = 0; m_active = '0; m_shadow = '0; m_pending = 0;
        m_idx = 0; m_nib = '0; m_en = '0; m_fs = 0;
      end else begin
        e++;
        entering = ((e - 1) % P) == 0;
        digit    = ((e - 1) / P) % N;
        is_wrap  = (e > 1) && (((e - 1) % (P * N)) == 0);
        if (is_wrap) begin
          if (load) m_active = value;
          else if (m_pending) m_active = m_shadow;
          m_pending = 0;
        end else if (load) begin
          m_shadow  = value;
          m_pending = 1;
        end
        m_fs = 0;
        if (entering) begin
          m_idx   = digit;
          m_nib   = m_active[4*digit +: 4];
          m_fs    = (digit == 0);
          blanked = blank_lz && (digit != 0) && ((m_active >> (4 * digit)) == 16'h0);
          m_en    = blanked ? 4'b0000 : (4'b0001 << digit);
        end
      end
      check("sb.fs", 32'(frame_start), 32'(m_fs));
      check("sb.idx", 32'(digit_idx), 32'(m_idx));
      check("sb.nib", 32'(nibble), 32'(m_nib));
      check("sb.en", 32'(digit_en), 32'(m_en));
    end
  end

  initial begin : stimulus
    repeat (3) @(negedge clk);
    check("rst.en", 32'(digit_en), 32'h0);
    check("rst.fs", 32'(frame_start), 32'h0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("start.fs", 32'(frame_start), 32'h1);
    check("start.en", 32'(digit_en), 32'h1);
    check("start.nib", 32'(nibble), 32'h0);

    // Idle scan, then a mid-frame load that must not show until the wrap.
    expect_frame("t1a", 16'h0000, 16'h8421, 0, '0, 0, '0, 0, '0);
    expect_frame("t1b", 16'h0000, 16'h8421, 1, 16'h1A2F, 0, '0, 0, '0);
    // Two loads in one frame: last wins.
    expect_frame("t2", 16'h1A2F, 16'h8421, 1, 16'h1234, 1, 16'h5678, 0, '0);
    // Parked load then a load on the wrap edge: wrap load wins, shadow dropped.
    expect_frame("t3", 16'h5678, 16'h8421, 1, 16'h1111, 0, '0, 1, 16'hBEEF);
    expect_frame("t4a", 16'hBEEF, 16'h8421, 0, '0, 0, '0, 0, '0);
    set_blank(1'b1);
    expect_frame("t4b", 16'hBEEF, 16'h8421, 1, 16'h0030, 0, '0, 0, '0);
    // Leading-zero blanking.
    expect_frame("t5a", 16'h0030, 16'h0021, 1, 16'h0000, 0, '0, 0, '0);
    expect_frame("t5b", 16'h0000, 16'h0001, 0, '0, 0, '0, 0, '0);

    // Reset during digit 2 with a load pending.
    set_blank(1'b0);
    repeat (P) @(negedge clk);
    sched_load(16'hABCD);
    repeat (P) @(negedge clk);
    check("t6.pre.idx", 32'(digit_idx), 32'h2);
    check("t6.pre.en", 32'(digit_en), 32'h4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6.async.en", 32'(digit_en), 32'h0);
    check("t6.async.idx", 32'(digit_idx), 32'h0);
    check("t6.async.nib", 32'(nibble), 32'h0);
    check("t6.async.fs", 32'(frame_start), 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t6.start.fs", 32'(frame_start), 32'h1);
    check("t6.start.nib", 32'(nibble), 32'h0);
    expect_frame("t6a", 16'h0000, 16'h8421, 0, '0, 0, '0, 0, '0);
    expect_frame("t6b", 16'h0000, 16'h8421, 0, '0, 0, '0, 0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
